cpu_test_harness: RTL and testbench
===================================

Name: cpu_test_harness

Overview:
- Synthesizable, parametrised self-checking harness for the multicycle RV32I core.
- Sequence: holds the CPU in reset, optionally zero-clears instruction/data memory, then streams a program image into memory over a valid/ready port.
- Then: releases the CPU, detects the halt idiom (JAL x0,0) or a cycle timeout, and reads back NUM_CHK register-file entries against expected values.
- Lets on-board and regression runs report pass/fail without hierarchical pokes.

Parameters:
- DATA_W, 32, memory/register data width.
- ADDR_W, 9, memory word-address width (2^ADDR_W words).
- PROG_LEN, 16, program words accepted per run (1..2^ADDR_W).
- NUM_CHK, 2, register checks per run (1..8).
- TIMEOUT, 1000, maximum RUN cycles before abort.
- HALT_WORD, 32'h0000006F, fetched instruction that signals halt.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset: rst==0 sampled at posedge resets the block
- start  in  1  one-cycle pulse, begins a run from IDLE or DONE
- prog_valid  in  1  program word valid
- prog_ready  out  1  harness accepts prog_data this cycle
- prog_data  in  DATA_W  program word, in address order
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- cpu_rst  out  1  active-high reset to CPU
- fetch_valid  in  1  CPU fetch strobe
- fetch_instr  in  DATA_W  instruction fetched
- rf_raddr  out  5  register-file debug read address
- rf_rdata  in  DATA_W  register-file debug read data, combinational from rf_raddr
- chk_reg  in  5*NUM_CHK  register index per check, check i at bits [5i+4:5i]
- chk_val  in  DATA_W*NUM_CHK  expected value per check
- busy  out  1  run in progress
- done  out  1  run finished, held until next start
- pass  out  1  all checks matched, valid when done
- timeout  out  1  RUN aborted by TIMEOUT
- fail_idx  out  3  first mismatching check index
- cycle_count  out  32  RUN cycles consumed

Behaviour:
- Reset values: prog_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, rf_raddr=0, busy=0, done=0, pass=0, timeout=0, fail_idx=0, cycle_count=0. State=IDLE.
- Reset mid-run aborts immediately to those values. No partial write completes after the reset edge.
- States and transitions: IDLE, CLEAR, LOAD, RUN, CHECK, DONE.
  - IDLE/DONE + start: clear done/pass/timeout/fail_idx/cycle_count, set busy=1, go to CLEAR. start is ignored in CLEAR..CHECK.
  - CLEAR: one word per cycle, mem_we=1, mem_wdata=0, mem_addr 0..2^ADDR_W-1. After the last address, mem_addr returns to 0 and the state goes to LOAD.
  - LOAD: prog_ready=1.
    - On prog_valid&&prog_ready, write prog_data at mem_addr the same cycle (mem_we=1) and increment mem_addr.
    - No write on stall cycles.
    - After word PROG_LEN-1 is accepted, deassert prog_ready the next cycle and go to RUN.
  - RUN: cpu_rst=0 from the first RUN cycle. cycle_count increments every RUN cycle (saturates at 2^32-1).
    - fetch_valid && fetch_instr==HALT_WORD: go to CHECK, cpu_rst=1 next cycle.
    - Else, if cycle_count==TIMEOUT-1 this cycle: timeout=1, pass=0, go to DONE.
    - Halt and timeout in the same cycle: halt wins.
  - CHECK: two cycles per index i=0..NUM_CHK-1.
    - Cycle A drives rf_raddr=chk_reg[i].
    - Cycle B compares rf_rdata to chk_val[i].
    - First mismatch: fail_idx=i, pass=0, go to DONE.
    - All match: pass=1, go to DONE.
    - CPU stays in reset, so the register file is frozen.
  - DONE: busy=0, done=1; all result outputs held until start or reset.
- Latency: CLEAR = 2^ADDR_W cycles; LOAD ≥ PROG_LEN cycles; CHECK = 2*NUM_CHK cycles on full pass.
- Width rules:
  - Compares are full DATA_W equality.
  - mem_addr wraps modulo 2^ADDR_W (PROG_LEN > 2^ADDR_W is illegal; assert in simulation).

Optional Feature:
- Macro CPU_HARNESS_CLEAR_EN.
- Defined: CLEAR state present as above.
- Undefined: CLEAR removed; start goes directly to LOAD with mem_addr=0, and memory beyond PROG_LEN retains prior contents.

Test Plan:
- Fibonacci image (15 words; halt word at index 14), x31 preset 10, PROG_LEN=15, chk0=(x10,55), chk1=(x31,10) -> done=1, pass=1, timeout=0, cycle_count<TIMEOUT.
- Same program, chk1=(x10,54) -> pass=0, fail_idx=1.
- Program with no halt word (BEQ x0,x0,0 loop), TIMEOUT=200 -> timeout=1, pass=0, cycle_count=200, CHECK never entered.
- prog_valid toggled every other cycle during LOAD -> memory contents identical to the unstalled run, LOAD takes 2*PROG_LEN cycles.
- rst=0 for one cycle in mid-RUN -> next cycle cpu_rst=1, busy=0, done=0, all outputs at reset values; a subsequent start reruns and passes.
- start pulsed during LOAD -> ignored; start in DONE -> flags clear and a new run begins.

Source files
------------

// File: rtl/cpu_test_harness.sv
// cpu_test_harness: self-checking run controller for the multicycle RV32I core.
// Holds the CPU in reset, optionally zero-fills memory, streams a program image in
// over a valid/ready port, releases the CPU, waits for the JAL x0,0 halt idiom or a
// cycle timeout, then compares NUM_CHK register-file entries against expected values.
// Optional feature: define CPU_HARNESS_CLEAR_EN to zero-fill memory before each load.
module cpu_test_harness #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 9,
    parameter int                PROG_LEN  = 16,
    parameter int                NUM_CHK   = 2,
    parameter int                TIMEOUT   = 1000,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(32'h0000006F)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    prog_valid,
    output logic                    prog_ready,
    input  logic [DATA_W-1:0]       prog_data,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    cpu_rst,
    input  logic                    fetch_valid,
    input  logic [DATA_W-1:0]       fetch_instr,
    output logic [4:0]              rf_raddr,
    input  logic [DATA_W-1:0]       rf_rdata,
    input  logic [5*NUM_CHK-1:0]    chk_reg,
    input  logic [DATA_W*NUM_CHK-1:0] chk_val,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [2:0]              fail_idx,
    output logic [31:0]             cycle_count
);

    // Illegal configurations stop elaboration rather than silently wrapping.
    if (PROG_LEN < 1 || PROG_LEN > (1 << ADDR_W)) begin : g_bad_prog_len
        $error("cpu_test_harness: PROG_LEN must be in 1..2**ADDR_W");
    end
    if (NUM_CHK < 1 || NUM_CHK > 8) begin : g_bad_num_chk
        $error("cpu_test_harness: NUM_CHK must be in 1..8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LOAD_LAST    = (ADDR_W+1)'(PROG_LEN - 1);
    localparam logic [31:0]     TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [2:0]      CHK_LAST     = 3'(NUM_CHK - 1);

    state_t              state;
    logic [ADDR_W:0]     load_cnt;   // words accepted; separate from mem_addr, which may wrap
    logic [2:0]          chk_idx;
    logic                chk_phase;  // 0: drive rf_raddr, 1: compare rf_rdata
    logic [4:0]          sel_reg;
    logic [DATA_W-1:0]   sel_val;

    // Current check's register index and expected value.
    always_comb begin
        sel_reg = chk_reg[5*chk_idx +: 5];
        sel_val = chk_val[DATA_W*chk_idx +: DATA_W];
    end

    // Write strobe and data follow the state register and the live handshake so a
    // word is written in the very cycle it is accepted; stalls never write.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state == S_CLEAR) begin
            mem_we = 1'b1;
        end else if (state == S_LOAD) begin
            mem_we    = prog_valid && prog_ready;
            mem_wdata = prog_data;
        end
    end

    // Run sequencer: state, address/count registers and all result flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            prog_ready  <= 1'b0;
            mem_addr    <= '0;
            cpu_rst     <= 1'b1;
            rf_raddr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_idx    <= '0;
            cycle_count <= '0;
            load_cnt    <= '0;
            chk_idx     <= '0;
            chk_phase   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        fail_idx    <= '0;
                        cycle_count <= '0;
                        busy        <= 1'b1;
                        cpu_rst     <= 1'b1;
                        mem_addr    <= '0;
                        load_cnt    <= '0;
`ifdef CPU_HARNESS_CLEAR_EN
                        state       <= S_CLEAR;
`else
                        state       <= S_LOAD;
                        prog_ready  <= 1'b1;
`endif
                    end
                end

`ifdef CPU_HARNESS_CLEAR_EN
                S_CLEAR: begin
                    mem_addr <= mem_addr + 1'b1;
                    // Address wraps back to zero as the last word is cleared.
                    if (mem_addr == '1) begin
                        state      <= S_LOAD;
                        prog_ready <= 1'b1;
                    end
                end
`endif

                S_LOAD: begin
                    if (prog_valid && prog_ready) begin
                        mem_addr <= mem_addr + 1'b1;
                        load_cnt <= load_cnt + 1'b1;
                        if (load_cnt == LOAD_LAST) begin
                            prog_ready <= 1'b0;
                            cpu_rst    <= 1'b0;
                            state      <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                    // Halt takes priority over a timeout landing in the same cycle.
                    if (fetch_valid && fetch_instr == HALT_WORD) begin
                        cpu_rst   <= 1'b1;
                        chk_idx   <= '0;
                        chk_phase <= 1'b0;
                        state     <= S_CHECK;
                    end else if (cycle_count == TIMEOUT_LAST) begin
                        cpu_rst <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end

                S_CHECK: begin
                    if (!chk_phase) begin
                        rf_raddr  <= sel_reg;
                        chk_phase <= 1'b1;
                    end else begin
                        chk_phase <= 1'b0;
                        if (rf_rdata != sel_val) begin
                            fail_idx <= chk_idx;
                            pass     <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end else if (chk_idx == CHK_LAST) begin
                            pass  <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            chk_idx <= chk_idx + 3'd1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_test_harness.sv
// Directed bench for cpu_test_harness: a tiny RV32I subset CPU stand-in (ADDI, ADD,
// BEQ/BNE, self-loop JAL) executes one instruction per cycle from a bench-side memory.
module tb_cpu_test_harness;

    localparam int DW   = 32;
    localparam int AW   = 6;
    localparam int PLEN = 15;
    localparam int NCHK = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic              prog_valid;
    logic              prog_ready;
    logic [DW-1:0]     prog_data;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              cpu_rst;
    logic              fetch_valid;
    logic [DW-1:0]     fetch_instr;
    logic [4:0]        rf_raddr;
    logic [DW-1:0]     rf_rdata;
    logic [5*NCHK-1:0] chk_reg;
    logic [DW*NCHK-1:0] chk_val;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [2:0]        fail_idx;
    logic [31:0]       cycle_count;

    int checks = 0;
    int failures = 0;

    cpu_test_harness #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .PROG_LEN (PLEN),
        .NUM_CHK  (NCHK),
        .TIMEOUT  (200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_valid  (prog_valid),
        .prog_ready  (prog_ready),
        .prog_data   (prog_data),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_rst     (cpu_rst),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .chk_reg     (chk_reg),
        .chk_val     (chk_val),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_idx    (fail_idx),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction/data memory written by the harness.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // CPU stand-in.
    logic [AW-1:0] pc;
    logic [DW-1:0] rf [32];
    logic [31:0]   ins, imm_i, imm_b;
    logic          br_taken;
    assign ins         = mem[pc];
    assign fetch_instr = ins;
    assign fetch_valid = !cpu_rst;
    assign rf_rdata    = rf[rf_raddr];
    assign imm_i       = {{20{ins[31]}}, ins[31:20]};
    assign imm_b       = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign br_taken    = (ins[6:0] == 7'h63) &&
                         (((ins[14:12] == 3'd0) && (rf[ins[19:15]] == rf[ins[24:20]])) ||
                          ((ins[14:12] == 3'd1) && (rf[ins[19:15]] != rf[ins[24:20]])));

    always @(posedge clk) begin
        if (cpu_rst) begin
            pc     <= '0;
            rf[0]  <= '0;
            rf[31] <= 32'd10;
        end else begin
            if (ins[6:0] == 7'h13 && ins[11:7] != 5'd0)
                rf[ins[11:7]] <= rf[ins[19:15]] + imm_i;
            if (ins[6:0] == 7'h33 && ins[11:7] != 5'd0)
                rf[ins[11:7]] <= rf[ins[19:15]] + rf[ins[24:20]];
            // JAL is only used here in its self-loop halt form.
            if (br_taken)                  pc <= pc + imm_b[AW+1:2];
            else if (ins[6:0] != 7'h6F)    pc <= pc + 1'b1;
        end
    end

    // Counts cycles spent in the register-check phase (busy, CPU held, not loading).
    int check_cycles;
    always @(posedge clk) begin
        if (start) check_cycles <= 0;
        else if (busy && cpu_rst && !prog_ready) check_cycles <= check_cycles + 1;
    end

    logic [31:0] img [PLEN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fibonacci: x10 = fib(x31) with x31 = 10, halt word at index 14.
    task automatic set_fib();
        img[0]  = 32'h00000093; // addi x1,x0,0
        img[1]  = 32'h00100113; // addi x2,x0,1
        img[2]  = 32'h00000193; // addi x3,x0,0
        img[3]  = 32'h00208233; // add  x4,x1,x2
        img[4]  = 32'h00010093; // addi x1,x2,0
        img[5]  = 32'h00020113; // addi x2,x4,0
        img[6]  = 32'h00118193; // addi x3,x3,1
        img[7]  = 32'hFFF198E3; // bne  x3,x31,-16
        img[8]  = 32'h00008513; // addi x10,x1,0
        for (int i = 9; i < 14; i++) img[i] = 32'h00000013;
        img[14] = 32'h0000006F; // jal x0,0
    endtask

    task automatic set_loop();
        img[0] = 32'h00000063;  // beq x0,x0,0
        for (int i = 1; i < PLEN; i++) img[i] = 32'h00000013;
    endtask

    task automatic chk_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < PLEN; i++) if (mem[i] !== img[i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_prog_ready"},  32'(prog_ready), 32'd0);
        chk({p, "_mem_we"},      32'(mem_we), 32'd0);
        chk({p, "_mem_addr"},    32'(mem_addr), 32'd0);
        chk({p, "_mem_wdata"},   mem_wdata, 32'd0);
        chk({p, "_cpu_rst"},     32'(cpu_rst), 32'd1);
        chk({p, "_rf_raddr"},    32'(rf_raddr), 32'd0);
        chk({p, "_busy"},        32'(busy), 32'd0);
        chk({p, "_done"},        32'(done), 32'd0);
        chk({p, "_pass"},        32'(pass), 32'd0);
        chk({p, "_timeout"},     32'(timeout), 32'd0);
        chk({p, "_fail_idx"},    32'(fail_idx), 32'd0);
        chk({p, "_cycle_count"}, cycle_count, 32'd0);
    endtask

    // Pulses start, streams img; stall toggles prog_valid every other ready cycle;
    // extra_start pulses start again on that loop iteration (negative: never).
    task automatic load_prog(input bit stall, input int extra_start, output int ready_cycles);
        int idx = 0;
        int it = 0;
        bit ph = 1'b0;
        ready_cycles = 0;
        @(negedge clk);
        start = 1'b1;
        while (idx < PLEN && it < 1000) begin
            @(negedge clk);
            it++;
            start = (it == extra_start);
            if (it == 1) begin
                chk("start_busy",        32'(busy), 32'd1);
                chk("start_done",        32'(done), 32'd0);
                chk("start_pass",        32'(pass), 32'd0);
                chk("start_timeout",     32'(timeout), 32'd0);
                chk("start_fail_idx",    32'(fail_idx), 32'd0);
                chk("start_cycle_count", cycle_count, 32'd0);
            end
            if (prog_ready) ready_cycles++;
            prog_valid = stall ? ph : 1'b1;
            prog_data  = img[idx];
            if (prog_ready && prog_valid) idx++;
            if (prog_ready) ph = ~ph;
        end
        chk("load_complete", 32'(idx), 32'(PLEN));
        @(negedge clk);
        start      = 1'b0;
        prog_valid = 1'b0;
        chk("load_ready_drop", 32'(prog_ready), 32'd0);
        chk("run_cpu_rst",     32'(cpu_rst), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", 32'(done), 32'd1);
    endtask

    int rc;

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        prog_valid = 1'b0;
        prog_data  = '0;
        chk_reg    = {5'd31, 5'd10};
        chk_val    = {32'd10, 32'd55};
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b1;

        // Passing Fibonacci run.
        set_fib();
        load_prog(1'b0, -1, rc);
        chk("fib_ready_cycles", 32'(rc), 32'd15);
        chk_mem("fib_mem");
        wait_done();
        chk("fib_pass",         32'(pass), 32'd1);
        chk("fib_timeout",      32'(timeout), 32'd0);
        chk("fib_fail_idx",     32'(fail_idx), 32'd0);
        chk("fib_cycle_count",  cycle_count, 32'd60);
        chk("fib_check_cycles", 32'(check_cycles), 32'd4);
        chk("fib_busy",         32'(busy), 32'd0);
        chk("fib_cpu_rst",      32'(cpu_rst), 32'd1);

        // Mismatch on check 1; a start pulse mid-LOAD must be ignored.
        chk_reg = {5'd10, 5'd10};
        chk_val = {32'd54, 32'd55};
        load_prog(1'b0, 5, rc);
        chk("bad_ready_cycles", 32'(rc), 32'd15);
        chk_mem("bad_mem");
        wait_done();
        chk("bad_pass",         32'(pass), 32'd0);
        chk("bad_fail_idx",     32'(fail_idx), 32'd1);
        chk("bad_cycle_count",  cycle_count, 32'd60);
        chk("bad_check_cycles", 32'(check_cycles), 32'd4);

        // No halt word: timeout after 200 RUN cycles.
        chk_reg = {5'd31, 5'd10};
        chk_val = {32'd10, 32'd55};
        set_loop();
        load_prog(1'b0, -1, rc);
        wait_done();
        chk("to_timeout",      32'(timeout), 32'd1);
        chk("to_pass",         32'(pass), 32'd0);
        chk("to_cycle_count",  cycle_count, 32'd200);
        chk("to_check_cycles", 32'(check_cycles), 32'd0);
        chk("to_cpu_rst",      32'(cpu_rst), 32'd1);

        // Stalled load: same memory image, twice the LOAD cycles.
        set_fib();
        load_prog(1'b1, -1, rc);
        chk("stall_ready_cycles", 32'(rc), 32'd30);
        chk_mem("stall_mem");
        wait_done();
        chk("stall_pass",        32'(pass), 32'd1);
        chk("stall_cycle_count", cycle_count, 32'd60);

        // Reset mid-RUN, then a clean rerun.
        load_prog(1'b0, -1, rc);
        repeat (20) @(negedge clk);
        chk("mid_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("mid_busy",    32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b1;
        load_prog(1'b0, -1, rc);
        wait_done();
        chk("rerun_pass",        32'(pass), 32'd1);
        chk("rerun_cycle_count", cycle_count, 32'd60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
